// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one 2x2 matrix multiplier between two requesters.
// Define MATMUL_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT cycles.
module matmul_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [63:0] rsp_c,
  output logic        rsp_err,
  output logic        busy,
  output logic        mm_start,
  output logic [31:0] mm_a,
  output logic [31:0] mm_b,
  input  logic [63:0] mm_c,
  input  logic        mm_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   owner;
  logic   win;
  logic   accept;
  logic   expired;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("matmul_arbiter: TIMEOUT must be within 2..255");
  end

`ifdef MATMUL_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
  logic       err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == WAIT) begin
      if (mm_done) begin
        err <= 1'b0;
      end else if (expired) begin
        err <= 1'b1;
      end
    end
  end

  assign expired = (cnt == TO_LAST);
  assign rsp_err = err;
`else
  assign expired = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Holding the accept off during reset keeps req_ready from promising a transfer that never happens.
  assign win    = req_valid[ptr] ? ptr : ~ptr;
  assign accept = rst_n && (|req_valid);

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready[win] = 1'b1;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (mm_done || expired) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mm_start  = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
      mm_a  <= '0;
      mm_b  <= '0;
      rsp_c <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        owner <= win;
        mm_a  <= win ? req_a1 : req_a0;
        mm_b  <= win ? req_b1 : req_b0;
      end
      if (state == WAIT) begin
        if (mm_done) begin
          rsp_c <= mm_c;
        end else if (expired) begin
          rsp_c <= '0;
        end
      end
      if (state == RESP) begin
        ptr <= ~owner;
      end
    end
  end

endmodule

// File: tb/tb_matmul_arbiter.sv
// Scoreboard bench for matmul_arbiter: directed requests, a delayed-done multiplier model,
// and a negedge monitor that checks every response against queued expectations.
module tb_matmul_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [63:0] rsp_c;
  logic        rsp_err, busy, mm_start;
  logic [31:0] mm_a, mm_b;
  logic [63:0] mm_c;
  logic        mm_done;

  logic        mdl_done = 1'b0;
  logic [63:0] mdl_c = '0;
  logic        stray = 1'b0;
  int          done_dly = 3;
  int          dly = 0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  who;
    logic [63:0] c;
    logic        err;
    int          at;
  } exp_t;
  exp_t sbq[$];

  // Hand-computed operand/result vectors
  localparam logic [31:0] V0A = 32'h0203_0405, V0B = 32'h0102_0304;
  localparam logic [63:0] V0C = 64'h000B_0010_0013_001C;
  localparam logic [31:0] V1A = 32'h0100_0001, V1B = 32'h1122_3344;
  localparam logic [63:0] V1C = 64'h0011_0022_0033_0044;
  localparam logic [31:0] V2A = 32'hFF00_00FF, V2B = 32'hFFFF_FFFF;
  localparam logic [63:0] V2C = 64'hFE01_FE01_FE01_FE01;
  localparam logic [31:0] V3A = 32'h0102_0304, V3B = 32'h0506_0708;
  localparam logic [63:0] V3C = 64'h0013_0016_002B_0032;

  matmul_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .busy(busy), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_c(mm_c), .mm_done(mm_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] x0, x1, x2, x3, y0, y1, y2, y3;
    x0 = 16'(a[31:24]); x1 = 16'(a[23:16]); x2 = 16'(a[15:8]); x3 = 16'(a[7:0]);
    y0 = 16'(b[31:24]); y1 = 16'(b[23:16]); y2 = 16'(b[15:8]); y3 = 16'(b[7:0]);
    return {16'(x0*y0 + x1*y2), 16'(x0*y1 + x1*y3), 16'(x2*y0 + x3*y2), 16'(x2*y1 + x3*y3)};
  endfunction

  // Multiplier model: done pulses done_dly cycles after start (0 = never)
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (mm_start) begin
      dly <= (done_dly != 0) ? done_dly - 1 : 0;
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        mdl_done <= 1'b1;
        mdl_c    <= mul(mm_a, mm_b);
      end
    end
  end
  assign mm_done = mdl_done | stray;
  assign mm_c    = mdl_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid !== 2'b00) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=rsp_valid %b required=none", rsp_valid);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_owner", 64'(rsp_valid), 64'(e.who));
        chk("rsp_c", rsp_c, e.c);
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Called at a negedge with requests already driven; returns at the ISSUE-cycle negedge.
  task automatic accept(input logic [1:0] exp_ready, input logic [63:0] exp_c,
                        input logic exp_err, input int lat, input bit push);
    int n;
    exp_t e;
    n = 0;
    #1;
    while (req_ready == 2'b00 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready == 2'b00) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no req_ready required=%b", exp_ready);
    end else begin
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      if (push) begin
        e.who = exp_ready; e.c = exp_c; e.err = exp_err; e.at = cyc + lat;
        sbq.push_back(e);
      end
      @(negedge clk);
      chk("mm_start", 64'(mm_start), 64'd1);
      chk("busy_issue", 64'(busy), 64'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_pending", 64'(sbq.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    // Reset check
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mm_start", 64'(mm_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mm_ab", {mm_a, mm_b}, 64'd0);
    chk("rst_rsp_c", rsp_c, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 0
    req_a0 = V0A; req_b0 = V0B; req_valid = 2'b01;
    accept(2'b01, V0C, 1'b0, 5, 1'b1);
    req_valid = 2'b00;
    drain();

    // Contention straight after reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a0 = V1A; req_b0 = V1B; req_a1 = V3A; req_b1 = V3B; req_valid = 2'b11;
    accept(2'b01, V1C, 1'b0, 5, 1'b1);
    accept(2'b10, V3C, 1'b0, 5, 1'b1);
    accept(2'b01, V1C, 1'b0, 5, 1'b1);
    accept(2'b10, V3C, 1'b0, 5, 1'b1);
    req_valid = 2'b00;
    drain();

    // Mid-operation reset: serve 0 (ptr->1), start 1, reset in WAIT, then ptr must be 0 again
    req_a0 = V0A; req_b0 = V0B; req_valid = 2'b01;
    accept(2'b01, V0C, 1'b0, 5, 1'b1);
    req_valid = 2'b00;
    drain();
    req_a1 = V3A; req_b1 = V3B; req_valid = 2'b10;
    accept(2'b10, V3C, 1'b0, 5, 1'b0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_mm_start", 64'(mm_start), 64'd0);
    req_a0 = V2A; req_b0 = V2B; req_valid = 2'b11;
    accept(2'b01, V2C, 1'b0, 5, 1'b1);
    req_valid = 2'b00;
    drain();

    // Stray done while idle
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_rsp_c_hold", rsp_c, V2C);

`ifdef MATMUL_ARB_TIMEOUT_EN
    // Multiplier never finishes: abort after TO WAIT cycles
    done_dly = 0;
    req_a1 = V1A; req_b1 = V1B; req_valid = 2'b10;
    accept(2'b10, 64'd0, 1'b1, 2 + TO, 1'b1);
    req_valid = 2'b00;
    drain();
    // Done arrives in the same cycle the watchdog expires: done wins
    done_dly = TO;
    req_a0 = V3A; req_b0 = V3B; req_valid = 2'b01;
    accept(2'b01, V3C, 1'b0, 2 + TO, 1'b1);
    req_valid = 2'b00;
    drain();
    done_dly = 3;
`endif

    chk("final_queue_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
